// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle ALU.
package alu_pkg;

   // Operation select, encoded as driven on alu_ctrl
   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_ORR  = 3'b011,
      OP_EOR  = 3'b100,
      OP_MUL  = 3'b101,
      OP_UDIV = 3'b110,
      OP_RSVD = 3'b111
   } alu_op_t;

   // Control FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Bit positions inside the {N,Z,C,V} flag vector
   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_iter_core.sv
// Iterative datapath: shift-add multiply (low half) and restoring unsigned divide,
// one step per clock, WIDTH steps per operation.
module alu_iter_core #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done_c,
   output logic [WIDTH-1:0] res_c
);

   // acc: product accumulator (MUL) or partial remainder (UDIV)
   // x  : shifting multiplicand (MUL) or divisor (UDIV)
   // y  : shifting multiplier (MUL) or dividend-in / quotient-out (UDIV)
   logic             busy_q, busy_d;
   logic             div_q, div_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH:0]   rem_sh_c;

   // Datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q <= 1'b0;
         div_q  <= 1'b0;
         cnt_q  <= '0;
         acc_q  <= '0;
         x_q    <= '0;
         y_q    <= '0;
      end else begin
         busy_q <= busy_d;
         div_q  <= div_d;
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         x_q    <= x_d;
         y_q    <= y_d;
      end
   end

   // One iteration step; res_c presents the value that this step produces
   always_comb begin
      busy_d   = busy_q;
      div_d    = div_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      x_d      = x_q;
      y_d      = y_q;
      done_c   = 1'b0;
      rem_sh_c = {acc_q, y_q[WIDTH-1]};

      if (start) begin
         busy_d = 1'b1;
         div_d  = is_div;
         cnt_d  = '0;
         acc_d  = '0;
         x_d    = b;
         y_d    = a;
      end else if (busy_q) begin
         if (div_q) begin
            // Bring down the next dividend bit and try to subtract the divisor
            if (rem_sh_c >= {1'b0, x_q}) begin
               acc_d = WIDTH'(rem_sh_c - {1'b0, x_q});
               y_d   = {y_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = rem_sh_c[WIDTH-1:0];
               y_d   = {y_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            if (y_q[0]) begin
               acc_d = acc_q + x_q;
            end
            x_d = x_q << 1;
            y_d = y_q >> 1;
         end
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == CW'(WIDTH - 1)) begin
            done_c = 1'b1;
            busy_d = 1'b0;
         end
      end

      // Division by zero yields zero rather than the all-ones raw quotient
      if (div_q) begin
         res_c = (x_q == '0) ? '0 : y_d;
      end else begin
         res_c = acc_d;
      end
   end

endmodule

// File: rtl/alu_multicycle.sv
// Handshaked ALU: single-cycle ADD/SUB/AND/ORR/EOR, iterative MUL/UDIV, NZCV flags.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_ctrl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             err
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       flags_q, flags_d;
   logic             err_q, err_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;

   alu_op_t          op_c;
   logic             sub_c;
   logic [WIDTH-1:0] b_eff_c;
   logic [WIDTH:0]   sum_c;
   logic [WIDTH-1:0] res_c;
   logic             carry_c, ovf_c, err_c, latch_c;
   logic             core_start_c, core_div_c, core_done_c;
   logic [WIDTH-1:0] core_res_c;

   alu_iter_core #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_iter (
      .clk    (clk),
      .reset  (reset),
      .start  (core_start_c),
      .is_div (core_div_c),
      .a      (a),
      .b      (b),
      .done_c (core_done_c),
      .res_c  (core_res_c)
   );

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         result_q    <= '0;
         flags_q     <= '0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Next state, single-cycle ops, flag generation and handshake outputs
   always_comb begin
      state_d      = state_q;
      result_d     = result_q;
      flags_d      = flags_q;
      err_d        = err_q;
      op_c         = alu_op_t'(alu_ctrl);
      sub_c        = 1'b0;
      b_eff_c      = '0;
      sum_c        = '0;
      res_c        = '0;
      carry_c      = 1'b0;
      ovf_c        = 1'b0;
      err_c        = 1'b0;
      latch_c      = 1'b0;
      core_start_c = 1'b0;
      core_div_c   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               case (op_c)
                  OP_ADD, OP_SUB: begin
                     sub_c   = (op_c == OP_SUB);
                     b_eff_c = sub_c ? ~b : b;
                     sum_c   = {1'b0, a} + {1'b0, b_eff_c} + {{WIDTH{1'b0}}, sub_c};
                     res_c   = sum_c[WIDTH-1:0];
                     carry_c = sum_c[WIDTH];
                     ovf_c   = (a[WIDTH-1] ~^ b_eff_c[WIDTH-1]) & (a[WIDTH-1] ^ sum_c[WIDTH-1]);
                     latch_c = 1'b1;
                  end
                  OP_AND: begin
                     res_c   = a & b;
                     latch_c = 1'b1;
                  end
                  OP_ORR: begin
                     res_c   = a | b;
                     latch_c = 1'b1;
                  end
                  OP_EOR: begin
                     res_c   = a ^ b;
                     latch_c = 1'b1;
                  end
                  OP_MUL, OP_UDIV: begin
                     core_start_c = 1'b1;
                     core_div_c   = (op_c == OP_UDIV);
                     state_d      = ST_BUSY;
                  end
                  default: begin
                     err_c   = 1'b1;
                     latch_c = 1'b1;
                  end
               endcase
               if (latch_c) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_BUSY: begin
            if (core_done_c) begin
               res_c   = core_res_c;
               latch_c = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (latch_c) begin
         result_d         = res_c;
         err_d            = err_c;
         flags_d[FLAG_N]  = res_c[WIDTH-1];
         flags_d[FLAG_Z]  = (res_c == '0);
         flags_d[FLAG_C]  = carry_c;
         flags_d[FLAG_V]  = ovf_c;
      end

      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;
   assign err       = err_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed table, random ops vs. a
// plain-arithmetic model, backpressure and asynchronous-reset sequences.
module tb_alu_multicycle;

   localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, ORR = 3'd3,
                          EOR = 3'd4, MUL = 3'd5, UDIV = 3'd6, RSVD = 3'd7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 32-bit instance
   logic        reset32, in_valid32, in_ready32, out_valid32, out_ready32, err32;
   logic [2:0]  ctrl32;
   logic [31:0] a32, b32, result32;
   logic [3:0]  flags32;

   // 8-bit instance
   logic        reset8, in_valid8, in_ready8, out_valid8, out_ready8, err8;
   logic [2:0]  ctrl8;
   logic [7:0]  a8, b8, result8;
   logic [3:0]  flags8;

   alu_multicycle #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(reset32), .in_valid(in_valid32), .in_ready(in_ready32),
      .alu_ctrl(ctrl32), .a(a32), .b(b32), .out_valid(out_valid32),
      .out_ready(out_ready32), .result(result32), .flags(flags32), .err(err32)
   );

   alu_multicycle #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset8), .in_valid(in_valid8), .in_ready(in_ready8),
      .alu_ctrl(ctrl8), .a(a8), .b(b8), .out_valid(out_valid8),
      .out_ready(out_ready8), .result(result8), .flags(flags8), .err(err8)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference model: results from plain unsigned arithmetic at width w
   function automatic void model(input int w, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic [3:0] f,
                                 output logic e);
      longint unsigned mask, aa, bb, s;
      bit c, v, sa, sb, sr;
      mask = (64'd1 << w) - 64'd1;
      aa = a & mask;
      bb = b & mask;
      sa = aa[w-1];
      sb = bb[w-1];
      c = 0; e = 0; s = 0;
      case (op)
         ADD:  begin s = aa + bb; c = s[w]; s = s & mask; end
         SUB:  begin s = (aa - bb) & mask; c = (aa >= bb); end
         AND_: s = aa & bb;
         ORR:  s = aa | bb;
         EOR:  s = aa ^ bb;
         MUL:  s = (aa * bb) & mask;
         UDIV: s = (bb == 0) ? 0 : aa / bb;
         default: begin s = 0; e = 1; end
      endcase
      sr = s[w-1];
      v = 0;
      if (op == ADD) v = (sa == sb) && (sr != sa);
      if (op == SUB) v = (sa != sb) && (sr != sa);
      r = 32'(s);
      f = {sr, (s == 0), c, v};
   endfunction

   // Issue one op on the 32-bit instance; lat = edges from accept to out_valid
   task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit consume, output logic [31:0] r, output logic [3:0] f,
                        output logic e, output int lat);
      int guard = 0;
      while (!in_ready32 && guard < 100) begin @(posedge clk); #1; guard++; end
      if (guard >= 100) chk("in_ready32_timeout", 0, 1);
      ctrl32 = op; a32 = a; b32 = b; in_valid32 = 1'b1;
      @(posedge clk); #1;
      in_valid32 = 1'b0;
      lat = 1;
      while (!out_valid32 && lat < 100) begin @(posedge clk); #1; lat++; end
      r = result32; f = flags32; e = err32;
      if (consume) begin
         out_ready32 = 1'b1;
         @(posedge clk); #1;
         out_ready32 = 1'b0;
      end
   endtask

   task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input bit consume, output logic [7:0] r, output logic [3:0] f,
                       output logic e, output int lat);
      int guard = 0;
      while (!in_ready8 && guard < 100) begin @(posedge clk); #1; guard++; end
      if (guard >= 100) chk("in_ready8_timeout", 0, 1);
      ctrl8 = op; a8 = a; b8 = b; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      lat = 1;
      while (!out_valid8 && lat < 100) begin @(posedge clk); #1; lat++; end
      r = result8; f = flags8; e = err8;
      if (consume) begin
         out_ready8 = 1'b1;
         @(posedge clk); #1;
         out_ready8 = 1'b0;
      end
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  flg;
      logic        err;
      int          lat;
   } vec_t;

   initial begin
      vec_t        tbl[15];
      logic [31:0] r, er;
      logic [7:0]  r8;
      logic [3:0]  f, ef;
      logic        e, ee;
      int          lat;
      logic [31:0] hold_r;
      logic [3:0]  hold_f;

      tbl[0]  = '{ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 1'b0, 1};
      tbl[1]  = '{SUB,  32'd5,        32'd5,        32'h00000000, 4'b0110, 1'b0, 1};
      tbl[2]  = '{SUB,  32'd3,        32'd5,        32'hFFFFFFFE, 4'b1000, 1'b0, 1};
      tbl[3]  = '{MUL,  32'h00010000, 32'h00010000, 32'h00000000, 4'b0100, 1'b0, 33};
      tbl[4]  = '{MUL,  32'd7,        32'd6,        32'd42,       4'b0000, 1'b0, 33};
      tbl[5]  = '{UDIV, 32'd100,      32'd7,        32'd14,       4'b0000, 1'b0, 33};
      tbl[6]  = '{UDIV, 32'd100,      32'd0,        32'd0,        4'b0100, 1'b0, 33};
      tbl[7]  = '{AND_, 32'hF0F0FFFF, 32'h0F0F00FF, 32'h000000FF, 4'b0000, 1'b0, 1};
      tbl[8]  = '{ORR,  32'h80000000, 32'h00000001, 32'h80000001, 4'b1000, 1'b0, 1};
      tbl[9]  = '{EOR,  32'hAAAA5555, 32'hAAAA5555, 32'h00000000, 4'b0100, 1'b0, 1};
      tbl[10] = '{RSVD, 32'd1,        32'd2,        32'h00000000, 4'b0100, 1'b1, 1};
      tbl[11] = '{ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, 1'b0, 1};
      tbl[12] = '{UDIV, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 4'b1000, 1'b0, 33};
      tbl[13] = '{MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 1'b0, 33};
      tbl[14] = '{SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011, 1'b0, 1};

      reset32 = 1'b1; in_valid32 = 1'b0; out_ready32 = 1'b0; ctrl32 = '0; a32 = '0; b32 = '0;
      reset8  = 1'b1; in_valid8  = 1'b0; out_ready8  = 1'b0; ctrl8  = '0; a8  = '0; b8  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid32, 0);
      chk("rst_in_ready",  in_ready32, 1);
      chk("rst_result",    result32, 0);
      chk("rst_flags",     flags32, 0);
      chk("rst_err",       err32, 0);
      chk("rst8_result",   result8, 0);
      reset32 = 1'b0;
      reset8  = 1'b0;
      @(posedge clk); #1;

      // Directed table
      for (int i = 0; i < 15; i++) begin
         run32(tbl[i].op, tbl[i].a, tbl[i].b, 1'b1, r, f, e, lat);
         chk($sformatf("tbl%0d_result", i), r, tbl[i].res);
         chk($sformatf("tbl%0d_flags", i),  f, tbl[i].flg);
         chk($sformatf("tbl%0d_err", i),    e, tbl[i].err);
         chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      end
      chk("after_consume_out_valid", out_valid32, 0);
      chk("after_consume_in_ready",  in_ready32, 1);

      // Random ops on both widths against the model
      for (int i = 0; i < 40; i++) begin
         logic [2:0]  op;
         logic [31:0] ra, rb;
         op = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         if (op == UDIV && $urandom_range(0, 3) == 0) rb = $urandom_range(0, 20);
         model(32, op, ra, rb, er, ef, ee);
         run32(op, ra, rb, 1'b1, r, f, e, lat);
         chk($sformatf("rnd%0d_op%0d_result", i, op), r, er);
         chk($sformatf("rnd%0d_op%0d_flags", i, op),  f, ef);
         chk($sformatf("rnd%0d_op%0d_err", i, op),    e, ee);
         chk($sformatf("rnd%0d_op%0d_latency", i, op), lat, (op == MUL || op == UDIV) ? 33 : 1);
      end
      for (int i = 0; i < 20; i++) begin
         logic [2:0] op;
         logic [7:0] ra, rb;
         op = 3'($urandom_range(0, 7));
         ra = 8'($urandom);
         rb = 8'($urandom);
         model(8, op, {24'd0, ra}, {24'd0, rb}, er, ef, ee);
         run8(op, ra, rb, 1'b1, r8, f, e, lat);
         chk($sformatf("rnd8_%0d_op%0d_result", i, op), r8, er[7:0]);
         chk($sformatf("rnd8_%0d_op%0d_flags", i, op),  f, ef);
         chk($sformatf("rnd8_%0d_op%0d_latency", i, op), lat, (op == MUL || op == UDIV) ? 9 : 1);
      end

      // Backpressure: hold DONE for 10 cycles while new requests are offered
      run32(SUB, 32'd3, 32'd5, 1'b0, r, f, e, lat);
      hold_r = r;
      hold_f = f;
      chk("bp_result_initial", hold_r, 32'hFFFFFFFE);
      for (int i = 0; i < 10; i++) begin
         ctrl32 = (i % 2 == 0) ? ADD : MUL;
         a32 = $urandom; b32 = $urandom;
         in_valid32 = 1'b1;
         @(posedge clk); #1;
         chk($sformatf("bp%0d_result", i),    result32, hold_r);
         chk($sformatf("bp%0d_flags", i),     flags32, hold_f);
         chk($sformatf("bp%0d_in_ready", i),  in_ready32, 0);
         chk($sformatf("bp%0d_out_valid", i), out_valid32, 1);
      end
      in_valid32 = 1'b0;
      out_ready32 = 1'b1;
      @(posedge clk); #1;
      out_ready32 = 1'b0;
      chk("bp_release_out_valid", out_valid32, 0);
      chk("bp_release_in_ready",  in_ready32, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_dropped_out_valid", out_valid32, 0);
      chk("bp_dropped_result",    result32, hold_r);

      // Reset at MUL iteration 12 on the 32-bit instance
      run32(ADD, 32'd1, 32'd1, 1'b1, r, f, e, lat);
      ctrl32 = MUL; a32 = 32'h1234; b32 = 32'h5678; in_valid32 = 1'b1;
      @(posedge clk); #1;
      in_valid32 = 1'b0;
      repeat (12) @(posedge clk);
      #2;
      chk("mid_mul_before_reset_result", result32, 32'd2);
      reset32 = 1'b1;
      #1;
      chk("mid_mul_reset_out_valid", out_valid32, 0);
      chk("mid_mul_reset_result",    result32, 0);
      chk("mid_mul_reset_flags",     flags32, 0);
      chk("mid_mul_reset_in_ready",  in_ready32, 1);
      @(posedge clk); #1;
      reset32 = 1'b0;
      run32(MUL, 32'd3, 32'd5, 1'b1, r, f, e, lat);
      chk("post_reset_mul_result",  r, 32'd15);
      chk("post_reset_mul_latency", lat, 33);

      // 8-bit instance: reset in DONE, reset mid-MUL, then ADD wrap
      run8(MUL, 8'h0F, 8'h11, 1'b1, r8, f, e, lat);
      chk("w8_mul_result",  r8, 8'hFF);
      chk("w8_mul_flags",   f, 4'b1000);
      chk("w8_mul_latency", lat, 9);
      run8(ADD, 8'h12, 8'h34, 1'b0, r8, f, e, lat);
      chk("w8_done_result", r8, 8'h46);
      #2;
      reset8 = 1'b1;
      #1;
      chk("w8_done_reset_out_valid", out_valid8, 0);
      chk("w8_done_reset_result",    result8, 0);
      @(posedge clk); #1;
      reset8 = 1'b0;
      ctrl8 = MUL; a8 = 8'h37; b8 = 8'h2B; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      reset8 = 1'b1;
      #1;
      chk("w8_mid_mul_reset_out_valid", out_valid8, 0);
      chk("w8_mid_mul_reset_in_ready",  in_ready8, 1);
      chk("w8_mid_mul_reset_flags",     flags8, 0);
      @(posedge clk); #1;
      reset8 = 1'b0;
      run8(ADD, 8'hFF, 8'h01, 1'b1, r8, f, e, lat);
      chk("w8_add_wrap_result",  r8, 8'h00);
      chk("w8_add_wrap_flags",   f, 4'b0110);
      chk("w8_add_wrap_latency", lat, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
